// File: rtl/capture_pkg.sv
// Shared definitions for the logic analyzer capture path: state encoding and
// default geometry used by the trigger, capture and host-link blocks.
package capture_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    READOUT = 2'd3
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
module capture_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/capture_buffer.sv
// Capture buffer: stores decimated samples while run is high, then streams
// them out over valid/ready with a one-entry skid stage for full throughput.
//
//   state   | meaning
//   IDLE    | nothing captured since reset
//   CAPTURE | writing samples while i_run is high
//   DONE    | capture finished, count/full valid, waiting for rd_start/new run
//   READOUT | streaming samples 0..count-1 to the consumer
module capture_buffer
  import capture_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DIV_W = DEF_DIV_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_run,
  input  logic [DIV_W-1:0]  i_divider,
  input  logic              i_rd_start,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_busy,
  output logic              o_rd_done
);

  localparam int CNT_W = ADDR_W + 1;

  state_t             state, state_nxt;
  logic               run_q;
  logic [DIV_W-1:0]   div_q, presc;
  logic [CNT_W-1:0]   count, rd_addr;
  logic               full;

  logic               idle_like, cap_start, rd_req, pop, last_xfer, rd_done_nxt;
  logic               wr_en, rd_en;
  logic [ADDR_W-1:0]  wr_addr, ram_rd_addr;
  logic [WIDTH-1:0]   ram_rdata;
  logic [1:0]         occ;

  logic               rvalid, skid_valid, out_valid, rd_done;
  logic [WIDTH-1:0]   skid_data, out_data;

  always_comb begin
    idle_like   = (state == IDLE) || (state == DONE);
    cap_start   = idle_like && i_run && !run_q;
    rd_req      = idle_like && i_rd_start && !cap_start;
    pop         = out_valid && i_rd_ready;
    occ         = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rvalid};
    last_xfer   = (state == READOUT) && pop && !skid_valid && !rvalid && (rd_addr == count);
    rd_done_nxt = last_xfer || (rd_req && (count == '0));

    wr_en   = !i_rst && (cap_start || ((state == CAPTURE) && i_run && (presc == '0)));
    wr_addr = cap_start ? '0 : count[ADDR_W-1:0];

    // Only fetch when the result is guaranteed a slot in out/skid.
    rd_en = !i_rst && ((rd_req && (count != '0)) ||
                       ((state == READOUT) && (rd_addr < count) &&
                        ((occ - {1'b0, pop}) < 2'd2)));
    ram_rd_addr = rd_req ? '0 : rd_addr[ADDR_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (cap_start)                      state_nxt = CAPTURE;
        else if (rd_req && (count != '0))   state_nxt = READOUT;
      end
      CAPTURE: begin
        if (!i_run)                                              state_nxt = DONE;
        else if ((presc == '0) && (count == CNT_W'(DEPTH - 1)))  state_nxt = DONE;
      end
      READOUT: begin
        if (last_xfer) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      run_q      <= 1'b0;
      div_q      <= '0;
      presc      <= '0;
      count      <= '0;
      full       <= 1'b0;
      rd_addr    <= '0;
      rvalid     <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      rd_done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_q   <= i_run;
      rd_done <= rd_done_nxt;
      rvalid  <= rd_en;

      if (cap_start) begin
        count <= CNT_W'(1);
        full  <= 1'b0;
        div_q <= i_divider;
        presc <= i_divider;
      end else if ((state == CAPTURE) && i_run) begin
        if (presc == '0) begin
          count <= count + CNT_W'(1);
          presc <= div_q;
          if (count == CNT_W'(DEPTH - 1)) full <= 1'b1;
        end else begin
          presc <= presc - DIV_W'(1);
        end
      end

      if (rd_en) rd_addr <= rd_req ? CNT_W'(1) : rd_addr + CNT_W'(1);

      // Output register refills from skid first, then from the RAM port.
      if (!out_valid || pop) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          skid_valid <= rvalid;
          if (rvalid) skid_data <= ram_rdata;
        end else begin
          out_valid <= rvalid;
          if (rvalid) out_data <= ram_rdata;
        end
      end else if (rvalid) begin
        skid_valid <= 1'b1;
        skid_data  <= ram_rdata;
      end
    end
  end

  capture_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (i_data),
    .i_rd_en   (rd_en),
    .i_rd_addr (ram_rd_addr),
    .o_rd_data (ram_rdata)
  );

  assign o_rd_data  = out_data;
  assign o_rd_valid = out_valid;
  assign o_count    = count;
  assign o_full     = full;
  assign o_busy     = (state == CAPTURE) || (state == READOUT);
  assign o_rd_done  = rd_done;

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer with a 16-deep buffer.
`timescale 1ns/1ps
module tb_capture_buffer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_run;
  logic [15:0] i_divider;
  logic        i_rd_start;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        i_rd_ready;
  logic [4:0]  o_count;
  logic        o_full;
  logic        o_busy;
  logic        o_rd_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_mem [16];

  always #5 i_clk = ~i_clk;

  capture_buffer #(.WIDTH(8), .DEPTH(16), .DIV_W(16)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_run      (i_run),
    .i_divider  (i_divider),
    .i_rd_start (i_rd_start),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_busy     (o_busy),
    .o_rd_done  (o_rd_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic rdy_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    return (cyc % 3) == 0;
  endfunction

  task automatic fill(input int n, input logic [7:0] base, input logic [7:0] stride);
    for (int k = 0; k < n; k++) exp_mem[k] = base + 8'(k) * stride;
  endtask

  task automatic capture(input int n, input logic [7:0] base, input logic [15:0] div);
    i_divider = div;
    for (int k = 0; k < n; k++) begin
      i_run  = 1'b1;
      i_data = base + 8'(k);
      step;
    end
    i_run = 1'b0;
    step;
  endtask

  task automatic read_all(input int n, input int mode, input bit run_mid);
    int   idx;
    int   cyc;
    int   first_v;
    logic held;
    logic [7:0] hold_d;
    idx = 0; first_v = -1; held = 1'b0; hold_d = '0;
    i_rd_ready = rdy_pat(mode, 0);
    i_rd_start = 1'b1;
    step;
    i_rd_start = 1'b0;
    chk("valid_at_t1", 32'(o_rd_valid), 32'd0);
    cyc = 1;
    while (idx < n && cyc < 200) begin
      i_rd_ready = rdy_pat(mode, cyc);
      if (run_mid && cyc == 3) i_run = 1'b1;
      if (o_rd_valid && first_v < 0) first_v = cyc;
      if (held) begin
        chk("stall_valid", 32'(o_rd_valid), 32'd1);
        chk("stall_data", 32'(o_rd_data), 32'(hold_d));
      end
      if (mode == 0 && cyc >= 2) chk("no_bubble", 32'(o_rd_valid), 32'd1);
      if (o_rd_valid && i_rd_ready) begin
        chk($sformatf("data[%0d]", idx), 32'(o_rd_data), 32'(exp_mem[idx]));
        idx++;
        held = 1'b0;
      end else begin
        held   = o_rd_valid;
        hold_d = o_rd_data;
      end
      step;
      cyc++;
    end
    chk("first_valid_cycle", 32'(first_v), 32'd2);
    chk("all_transferred", 32'(idx), 32'(n));
    chk("done_pulse", 32'(o_rd_done), 32'd1);
    chk("valid_drop", 32'(o_rd_valid), 32'd0);
    chk("busy_after_read", 32'(o_busy), 32'd0);
    step;
    chk("done_one_cycle", 32'(o_rd_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_data = '0; i_run = 1'b0; i_divider = '0;
    i_rd_start = 1'b0; i_rd_ready = 1'b0;
    step; step; step;
    i_rst = 1'b0;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_rd_done), 32'd0);
    chk("rst_data", 32'(o_rd_data), 32'd0);

    // Readout request with nothing stored
    i_rd_start = 1'b1;
    step;
    i_rd_start = 1'b0;
    chk("empty_done", 32'(o_rd_done), 32'd1);
    chk("empty_valid", 32'(o_rd_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step;
      chk("empty_valid_after", 32'(o_rd_valid), 32'd0);
      chk("empty_done_after", 32'(o_rd_done), 32'd0);
    end

    // Basic
    capture(5, 8'h10, 16'd0);
    chk("basic_count", 32'(o_count), 32'd5);
    chk("basic_full", 32'(o_full), 32'd0);
    chk("basic_busy", 32'(o_busy), 32'd0);
    fill(5, 8'h10, 8'd1);
    read_all(5, 0, 1'b0);

    // Decimated: divider 2, samples at cycles 0,3,6,9
    capture(10, 8'h00, 16'd2);
    chk("dec_count", 32'(o_count), 32'd4);
    chk("dec_full", 32'(o_full), 32'd0);
    fill(4, 8'h00, 8'd3);
    read_all(4, 0, 1'b0);

    // Overflow
    i_divider = 16'd0;
    for (int k = 0; k < 40; k++) begin
      i_run  = 1'b1;
      i_data = 8'h40 + 8'(k);
      step;
      if (k == 14) chk("ovf_busy_before", 32'(o_busy), 32'd1);
      if (k == 15) begin
        chk("ovf_stopped", 32'(o_busy), 32'd0);
        chk("ovf_full_early", 32'(o_full), 32'd1);
      end
    end
    i_run = 1'b0;
    step;
    chk("ovf_count", 32'(o_count), 32'd16);
    chk("ovf_full", 32'(o_full), 32'd1);
    fill(16, 8'h40, 8'd1);
    read_all(16, 0, 1'b0);

    // Backpressure
    capture(8, 8'hA0, 16'd0);
    chk("bp_count", 32'(o_count), 32'd8);
    chk("bp_full", 32'(o_full), 32'd0);
    fill(8, 8'hA0, 8'd1);
    read_all(8, 1, 1'b0);

    // Readout request during capture is ignored
    i_divider = 16'd0;
    for (int k = 0; k < 6; k++) begin
      i_run      = 1'b1;
      i_data     = 8'h20 + 8'(k);
      i_rd_start = (k == 3);
      step;
      if (k >= 3) begin
        chk("cap_rdstart_valid", 32'(o_rd_valid), 32'd0);
        chk("cap_rdstart_done", 32'(o_rd_done), 32'd0);
      end
    end
    i_rd_start = 1'b0;
    i_run = 1'b0;
    step;
    chk("cap_rdstart_count", 32'(o_count), 32'd6);

    // Run edge during readout must not start a capture
    fill(6, 8'h20, 8'd1);
    read_all(6, 1, 1'b1);
    step;
    chk("run_in_read_busy", 32'(o_busy), 32'd0);
    chk("run_in_read_count", 32'(o_count), 32'd6);
    i_run = 1'b0;
    step;

    // Reset mid-readout after three transfers
    capture(8, 8'hB0, 16'd0);
    i_rd_ready = 1'b1;
    i_rd_start = 1'b1;
    step;
    i_rd_start = 1'b0;
    step;
    chk("rr_data0", 32'(o_rd_data), 32'hB0);
    step;
    chk("rr_data1", 32'(o_rd_data), 32'hB1);
    step;
    chk("rr_data2", 32'(o_rd_data), 32'hB2);
    step;
    i_rst = 1'b1;
    step;
    chk("rr_valid", 32'(o_rd_valid), 32'd0);
    chk("rr_count", 32'(o_count), 32'd0);
    chk("rr_busy", 32'(o_busy), 32'd0);
    chk("rr_full", 32'(o_full), 32'd0);
    chk("rr_data", 32'(o_rd_data), 32'd0);
    i_rst = 1'b0;
    i_rd_ready = 1'b0;
    step;
    chk("rr_valid_after", 32'(o_rd_valid), 32'd0);

    // Fresh capture after reset, divider 1
    capture(5, 8'hC0, 16'd1);
    chk("post_rst_count", 32'(o_count), 32'd3);
    fill(3, 8'hC0, 8'd2);
    read_all(3, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
